prng_feed_sched: RTL
====================

Name: prng_feed_sched

Overview:
- Round-robin scheduler that shares one masked-randomness source stream (BUS_SIZE-bit words) between NREQ consumers in the masked datapath.
- Consumers are the key-holder share refresh, Clyde PRNG1 feed and Clyde PRNG2 feed.
- Each consumer requests a burst of words. The scheduler grants one consumer at a time, routes the valid/ready handshake to it, counts words, and pulses done at the end of the burst.
- Sits between the randomness source and the datapath. The top-level controller drives hold and flush.

Parameters:
- NREQ, 3, number of requesters (2..8).
- BUS_SIZE, 32, width of one randomness word.
- LEN_W, 8, width of the per-requester burst-length field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester burst request (level).
- req_len  in  NREQ*LEN_W  burst length minus 1, one field per requester; requester i uses bits [i*LEN_W +: LEN_W].
- hold  in  1  blocks new grants; an ongoing burst continues.
- flush  in  1  synchronous abort back to IDLE.
- src_data  in  BUS_SIZE  randomness word from the source.
- src_valid  in  1  source word valid.
- src_ready  out  1  source word accepted.
- dst_data  out  BUS_SIZE  broadcast copy of src_data (combinational).
- dst_valid  out  NREQ  per-requester word valid.
- dst_ready  in  NREQ  per-requester ready.
- grant  out  NREQ  one-hot registered grant.
- busy  out  1  high in XFER or DONE.
- done  out  NREQ  one-cycle burst-complete pulse.
- words_left  out  LEN_W  remaining handshakes minus 1 in the current burst.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant=0, done=0, busy=0, words_left=0, rr_ptr=0.
  - src_ready=0, dst_valid=0.
- States: IDLE, XFER, DONE.
- IDLE:
  - If hold=0 and req!=0, select the first set req[i] searching i = rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On the next edge: grant=onehot(i), words_left=req_len[i], state=XFER.
  - grant becomes visible 1 cycle after req is sampled.
  - If hold=1 or req=0, stay in IDLE.
- XFER:
  - dst_valid[g] = src_valid; all other dst_valid bits = 0.
  - src_ready = dst_ready[g]; combinational pass-through, zero added latency.
  - A handshake is src_valid & src_ready.
  - A handshake with words_left>0 decrements words_left.
  - A handshake with words_left==0 moves to DONE.
  - A burst is exactly req_len+1 words; there is no empty burst.
  - src_valid=0 stalls the burst indefinitely; no timeout.
  - Deasserting req[g] or asserting hold mid-burst is ignored; the burst completes.
- DONE (one cycle):
  - done[g]=1, src_ready=0, dst_valid=0.
  - On the next edge: grant=0, rr_ptr=(g+1) mod NREQ, state=IDLE.
  - The requester must drop req by the cycle after done. If req is still high in IDLE, it is treated as a new request.
- Minimum arbitration gap: 2 idle handshake cycles between bursts (DONE, then IDLE select).
- flush=1, any state:
  - Next edge: state=IDLE, grant=0, words_left=0, no done pulse, rr_ptr unchanged.
  - flush has priority over every transition.
  - In the flush cycle the data path is still live. The controller must not assert flush when it cannot tolerate a consumed word.
- Outside XFER: src_ready=0 and dst_valid=0.
- busy = state!=IDLE.
- Invariant: grant is one-hot or zero.

Test Plan:
- Single burst: req=3'b010, req_len[1]=3, src_valid=1, dst_ready[1]=1.
  - grant=3'b010 one cycle after req.
  - Exactly 4 handshakes on consecutive cycles.
  - done[1] pulses the following cycle; src_ready never asserted afterwards.
- Round-robin: req=3'b111 held, all req_len=0.
  - Grants in order 001, 010, 100, 001, each burst 1 word.
  - done pulses in the same order.
  - 3-cycle period per grant (IDLE, XFER, DONE).
- Backpressure: grant on requester 0, req_len=2; dst_ready[0] toggles 1,0,0,1,1; src_valid=1.
  - 3 handshakes total; words_left goes 2→1→0.
  - done[0] pulses after the 5th cycle.
  - dst_valid[2:1]=0 throughout.
- hold: hold=1 with req=3'b001 → grant stays 0.
  - Release hold → grant=3'b001 next cycle.
  - Asserting hold mid-burst does not stop the words.
- flush mid-burst: requester 2, req_len=7, flush after 3 handshakes.
  - Next cycle: IDLE, grant=0, no done pulse.
  - With req=3'b100 still high, the next grant goes to requester 2; rr_ptr unchanged.
- Async reset mid-XFER: rst pulsed between clock edges.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release and req=3'b110, the first grant is 3'b010 (rr_ptr=0 search).

Source files
------------

// File: rtl/prng_feed_sched.sv
// Round-robin scheduler sharing one randomness word stream between NREQ
// consumers; grants one burst at a time and routes the handshake to the winner.
module prng_feed_sched #(
  parameter int NREQ     = 3,
  parameter int BUS_SIZE = 32,
  parameter int LEN_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [BUS_SIZE-1:0]   src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [BUS_SIZE-1:0]   dst_data,
  output logic [NREQ-1:0]       dst_valid,
  input  logic [NREQ-1:0]       dst_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  output logic [LEN_W-1:0]      words_left
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic             hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      gidx_q       <= '0;
      rr_ptr_q     <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      gidx_q       <= gidx_d;
      rr_ptr_q     <= rr_ptr_d;
      words_left_q <= words_left_d;
    end
  end

  // Search starts at rr_ptr and wraps, so the last-served requester goes last.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && req[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    rr_ptr_d     = rr_ptr_q;
    words_left_d = words_left_q;
    case (state_q)
      IDLE: begin
        if (!hold && sel_found) begin
          state_d      = XFER;
          grant_d      = NREQ'(1) << sel_idx;
          gidx_d       = sel_idx;
          words_left_d = req_len[sel_idx*LEN_W +: LEN_W];
        end
      end
      XFER: begin
        if (hs) begin
          if (words_left_q == '0) state_d = DONE;
          else                    words_left_d = words_left_q - 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (gidx_q == PTR_W'(NREQ-1)) ? '0 : gidx_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    // Abort wins over everything and leaves the fairness pointer alone.
    if (flush) begin
      state_d      = IDLE;
      grant_d      = '0;
      words_left_d = '0;
      rr_ptr_d     = rr_ptr_q;
    end
  end

  always_comb begin
    src_ready = (state_q == XFER) && dst_ready[gidx_q];
    dst_valid = (state_q == XFER && src_valid) ? grant_q : '0;
    done      = (state_q == DONE) ? grant_q : '0;
    dst_data  = src_data;
    grant     = grant_q;
    busy      = (state_q != IDLE);
    words_left = words_left_q;
  end

  assign hs = src_valid & src_ready;

endmodule
